// File: rtl/axi_sync_reg_counter.sv
// axi_sync_reg_counter: AXI4-Lite slave with CNT (RO), RUN (RW) and TRIGGER (WO) registers.
// Define AXI_CNT_CLEAR_EN to map a write-only CLEAR register at offset 0x18.
module axi_sync_reg_counter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    logic                  live, aw_full, w_full, run;
    logic                  aw_hs, w_hs, ar_hs, commit, trig, clr;
    logic [1:0]            aw_sel, wr_sel;
    logic [DATA_WIDTH-1:0] w_data, wr_data, cnt, rd_mux;
    logic                  unused_bits;

    // live keeps every ready low while reset is held and for the first cycle after it
    assign s_axi_awready = live && !aw_full && !s_axi_bvalid;
    assign s_axi_wready  = live && !w_full && !s_axi_bvalid;
    assign s_axi_arready = live && !s_axi_rvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;
    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign wr_sel  = aw_full ? aw_sel : s_axi_awaddr[4:3];
    assign wr_data = w_full ? w_data : s_axi_wdata;
    assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
    assign trig    = commit && wr_sel == 2'd2;
`ifdef AXI_CNT_CLEAR_EN
    assign clr = commit && wr_sel == 2'd3;
`else
    assign clr = 1'b0;
`endif
    assign rd_mux = s_axi_araddr[4:3] == 2'd0 ? cnt :
                    s_axi_araddr[4:3] == 2'd1 ? DATA_WIDTH'(run) : '0;
    assign unused_bits = ^{s_axi_wstrb, s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[2:0],
                           s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[2:0]};

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            live         <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_sel       <= '0;
            w_data       <= '0;
            run          <= 1'b0;
            cnt          <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            live         <= 1'b1;
            aw_full      <= (aw_full || aw_hs) && !commit;
            w_full       <= (w_full || w_hs) && !commit;
            if (aw_hs) aw_sel <= s_axi_awaddr[4:3];
            if (w_hs) w_data <= s_axi_wdata;
            if (commit && wr_sel == 2'd1) run <= wr_data[0];
            cnt          <= clr ? '0 : cnt + (trig ? wr_data : '0) + DATA_WIDTH'(run);
            s_axi_bvalid <= commit || (s_axi_bvalid && !s_axi_bready);
            if (ar_hs) s_axi_rdata <= rd_mux;
            s_axi_rvalid <= ar_hs || (s_axi_rvalid && !s_axi_rready);
        end
    end
endmodule

// File: tb/tb_axi_sync_reg_counter.sv
// tb_axi_sync_reg_counter: directed and randomized AXI4-Lite traffic against a
// plain-arithmetic model of CNT/RUN.
module tb_axi_sync_reg_counter;
    logic        tb_ACLK = 1'b0;
    logic        tb_ARESETn = 1'b0;
    logic [7:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '1;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    int          checks = 0, errors = 0;
    longint      cycle = 0;
    logic [31:0] model_cnt;

    axi_sync_reg_counter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .ACLK(tb_ACLK), .ARESETn(tb_ARESETn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 tb_ACLK = ~tb_ACLK;
    always @(posedge tb_ACLK) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input int order, input int bdelay);
        bit aw_done = 0, w_done = 0;
        logic aw_hs, w_hs;
        int n = 0;
        s_axi_awaddr = addr;
        s_axi_wdata = data;
        s_axi_awvalid = (order != 2);
        s_axi_wvalid = (order != 1);
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs = s_axi_wvalid && s_axi_wready;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 0; end
            if (w_hs) begin w_done = 1; s_axi_wvalid = 0; end
            if (order == 2 && w_done && !aw_done) s_axi_awvalid = 1;
            if (order == 1 && aw_done && !w_done) s_axi_wvalid = 1;
        end
        s_axi_awvalid = 0;
        s_axi_wvalid = 0;
        check("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin tick(); n++; end
        check("bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        repeat (bdelay) begin
            tick();
            check("bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
        end
        check("bresp", {30'd0, s_axi_bresp}, 32'd0);
        s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        check("bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output longint hs_cycle);
        int n = 0;
        s_axi_araddr = addr;
        s_axi_arvalid = 1;
        while (!s_axi_arready && n < 20) begin tick(); n++; end
        tick();
        s_axi_arvalid = 0;
        hs_cycle = cycle;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin tick(); n++; end
        check("rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        check("rresp", {30'd0, s_axi_rresp}, 32'd0);
        data = s_axi_rdata;
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("rdata_stable", s_axi_rdata, data);
        end
        s_axi_rready = 1;
        tick();
        s_axi_rready = 0;
        check("rvalid_clear", {31'd0, s_axi_rvalid}, 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        longint c;
        axi_read(addr, d, c);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] v1, v2, v3, v4, d;
        longint c1, c2, c3;
        repeat (3) tick();
        check("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        check("rst_wready", {31'd0, s_axi_wready}, 32'd0);
        check("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        check("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        tb_ARESETn = 1;
        repeat (2) tick();
        read_expect("cnt_reset", 8'h00, 32'd0);
        read_expect("run_reset", 8'h08, 32'd0);

        model_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            axi_write(8'h10, i, $urandom_range(0, 2), $urandom_range(0, 3));
            model_cnt += i;
        end
        read_expect("cnt_trig_sum", 8'h00, 32'd6);
        read_expect("run_still0", 8'h08, 32'd0);

        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    axi_write(8'h10 | 8'($urandom_range(0, 7)), d, $urandom_range(0, 2), $urandom_range(0, 2));
                    model_cnt += d;
                end
                1: axi_write(8'h08, d & 32'hFFFF_FFFE, $urandom_range(0, 2), $urandom_range(0, 2));
                2: axi_write(8'h00, d, $urandom_range(0, 2), $urandom_range(0, 2));
                default: read_expect("wo_reads0", ($urandom_range(0, 1) != 0) ? 8'h10 : 8'h18, 32'd0);
            endcase
            read_expect("cnt_random", 8'h00, model_cnt);
        end
        read_expect("run_after_random", 8'h08, 32'd0);

        axi_write(8'h08, 32'd1, 0, 0);
        repeat (5) tick();
        axi_read(8'h00, v1, c1);
        check("run_grows_gt", {31'd0, v1 > model_cnt}, 32'd1);
        read_expect("run_set", 8'h08, 32'd1);
        axi_read(8'h00, v2, c2);
        check("run_rate", v2 - v1, 32'(c2 - c1));

        axi_write(8'h08, 32'd0, 1, 1);
        axi_read(8'h00, v3, c3);
        repeat (10) tick();
        axi_read(8'h00, v4, c3);
        check("frozen", v4, v3);
        check("frozen_gt", {31'd0, v3 > v2}, 32'd1);
        model_cnt = v3;

        axi_write(8'h10, 32'hFFFF_FFFE - model_cnt, $urandom_range(0, 2), 0);
        model_cnt = 32'hFFFF_FFFE;
        read_expect("cnt_preset", 8'h00, model_cnt);
        axi_write(8'h10, 32'd3, 2, 4);
        model_cnt = model_cnt + 32'd3;
        read_expect("cnt_wrap", 8'h00, 32'd1);

        axi_write(8'h10, 32'd5, 0, 0);
        model_cnt = model_cnt + 32'd5;
        read_expect("cnt_pre_clear", 8'h00, 32'd6);
        axi_write(8'h18, $urandom, $urandom_range(0, 2), 1);
`ifdef AXI_CNT_CLEAR_EN
        model_cnt = 0;
`endif
        read_expect("cnt_clear", 8'h00, model_cnt);
        read_expect("clear_reads0", 8'h18, 32'd0);

        axi_write(8'h10, 32'd10, 0, 0);
        axi_write(8'h08, 32'd1, 0, 0);
        s_axi_awaddr = 8'h10;
        s_axi_awvalid = 1;
        tick();
        tb_ARESETn = 0;
        s_axi_awvalid = 0;
        repeat (2) tick();
        check("midrst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        check("midrst_awready", {31'd0, s_axi_awready}, 32'd0);
        tb_ARESETn = 1;
        repeat (2) tick();
        read_expect("midrst_cnt", 8'h00, 32'd0);
        read_expect("midrst_run", 8'h08, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
